// File: rtl/reg_file_dumper_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_dumper_pkg
//
// Shared definitions for the register-file dump path:
//   DEF_DATA_W  default register width in bits
//   DEF_ADDR_W  default register address width
//   NUM_REGS    number of registers addressed (2**DEF_ADDR_W)
//   state_t     controller state encoding (idle / running a dump)
// -----------------------------------------------------------------------------
package reg_file_dumper_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int NUM_REGS   = 2 ** DEF_ADDR_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage : reg_file_dumper_pkg

// File: rtl/reg_file_dumper_if.sv
// -----------------------------------------------------------------------------
// reg_file_dumper_if
//
// Bundles every non-clock/reset signal of the dumper.
//   start/first_reg/last_reg   dump request and inclusive address range
//   rf_read_reg/rf_read_data   one register-file read port (combinational data)
//   out_valid/out_ready        output stream handshake
//   out_reg/out_data           register number and value of the current beat
//   busy/done/checksum         status: dump running, end pulse, XOR of beats
//
// Modports:
//   master  the dumper itself
//   slave   the environment (requester, register file, stream consumer)
// -----------------------------------------------------------------------------
interface reg_file_dumper_if
  import reg_file_dumper_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              start;
  logic [ADDR_W-1:0] first_reg;
  logic [ADDR_W-1:0] last_reg;
  logic [ADDR_W-1:0] rf_read_reg;
  logic [DATA_W-1:0] rf_read_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_reg;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] checksum;

  modport master (
    input  start,
    input  first_reg,
    input  last_reg,
    output rf_read_reg,
    input  rf_read_data,
    output out_valid,
    input  out_ready,
    output out_reg,
    output out_data,
    output busy,
    output done,
    output checksum
  );

  modport slave (
    output start,
    output first_reg,
    output last_reg,
    input  rf_read_reg,
    output rf_read_data,
    input  out_valid,
    output out_ready,
    input  out_reg,
    input  out_data,
    input  busy,
    input  done,
    input  checksum
  );

endinterface : reg_file_dumper_if

// File: rtl/reg_file_dumper.sv
// -----------------------------------------------------------------------------
// reg_file_dumper
//
// Walks an inclusive, wrapping register address range through one read port
// of the register file and streams (register number, value) beats out over a
// valid/ready handshake, one beat per cycle at best. An XOR checksum of the
// accepted beats is kept and held until the next dump starts.
//
// Ports:
//   clk     clock, all state changes on the rising edge
//   rst     synchronous active-high reset; aborts a dump without done
//   io_bus  reg_file_dumper_if.master: request, read port, stream, status
//
// Timing: the read address is registered, so the first beat is valid two
// cycles after the start cycle. done pulses the cycle after the last
// handshake; busy stays high through that cycle so a start coinciding with
// done is ignored.
// -----------------------------------------------------------------------------
module reg_file_dumper
  import reg_file_dumper_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  reg_file_dumper_if.master io_bus
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            r_state;
  logic [ADDR_W-1:0] r_rd_addr;
  // Beats still to fetch; needs one extra bit to hold a full 2**ADDR_W range.
  logic [ADDR_W:0]   r_remaining;
  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_reg;
  logic [DATA_W-1:0] r_out_data;
  logic [DATA_W-1:0] r_checksum;
  logic              r_done;

  state_t            w_state_next;
  logic [ADDR_W-1:0] w_rd_addr_next;
  logic [ADDR_W:0]   w_remaining_next;
  logic              w_out_valid_next;
  logic [ADDR_W-1:0] w_out_reg_next;
  logic [DATA_W-1:0] w_out_data_next;
  logic [DATA_W-1:0] w_checksum_next;
  logic              w_done_next;

  logic              w_fire;
  logic              w_fetch;
  logic [ADDR_W-1:0] w_span;

  // Distance from first to last, modulo the register count; a range of
  // N registers gives w_span = N-1, so first==last is one beat and
  // last==first-1 is a full sweep.
  assign w_span = io_bus.last_reg - io_bus.first_reg;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rd_addr   <= '0;
      r_remaining <= '0;
      r_out_valid <= 1'b0;
      r_out_reg   <= '0;
      r_out_data  <= '0;
      r_checksum  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_rd_addr   <= w_rd_addr_next;
      r_remaining <= w_remaining_next;
      r_out_valid <= w_out_valid_next;
      r_out_reg   <= w_out_reg_next;
      r_out_data  <= w_out_data_next;
      r_checksum  <= w_checksum_next;
      r_done      <= w_done_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next     = r_state;
    w_rd_addr_next   = r_rd_addr;
    w_remaining_next = r_remaining;
    w_out_valid_next = r_out_valid;
    w_out_reg_next   = r_out_reg;
    w_out_data_next  = r_out_data;
    w_checksum_next  = r_checksum;
    w_done_next      = 1'b0;
    w_fire           = r_out_valid & io_bus.out_ready;
    w_fetch          = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (io_bus.start) begin
          w_state_next     = ST_RUN;
          w_rd_addr_next   = io_bus.first_reg;
          w_remaining_next = {1'b0, w_span} + (ADDR_W + 1)'(1);
          w_checksum_next  = '0;
        end
      end

      ST_RUN: begin
        if (r_done) begin
          // done cycle: the stream is already empty, just release busy.
          w_state_next = ST_IDLE;
        end else begin
          // The output stage can take a new beat when it is empty or its
          // current beat is leaving this cycle.
          w_fetch = (r_remaining != '0) && (!r_out_valid || io_bus.out_ready);

          if (w_fire) begin
            w_checksum_next = r_checksum ^ r_out_data;
          end

          if (w_fetch) begin
            // rf_read_data is sampled at the edge, so a register-file write
            // landing on the same edge is not seen: the old value is dumped.
            w_out_data_next  = io_bus.rf_read_data;
            w_out_reg_next   = r_rd_addr;
            w_out_valid_next = 1'b1;
            w_rd_addr_next   = r_rd_addr + ADDR_W'(1);
            w_remaining_next = r_remaining - (ADDR_W + 1)'(1);
          end else if (w_fire) begin
            w_out_valid_next = 1'b0;
          end

          // Nothing left to fetch and the held beat is accepted: last beat.
          if (w_fire && (r_remaining == '0)) begin
            w_done_next = 1'b1;
          end
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign io_bus.rf_read_reg = r_rd_addr;
  assign io_bus.out_valid   = r_out_valid;
  assign io_bus.out_reg     = r_out_reg;
  assign io_bus.out_data    = r_out_data;
  assign io_bus.busy        = (r_state == ST_RUN);
  assign io_bus.done        = r_done;
  assign io_bus.checksum    = r_checksum;

endmodule : reg_file_dumper

// File: tb/tb_reg_file_dumper.sv
// -----------------------------------------------------------------------------
// tb_reg_file_dumper
//
// Drives dump requests against a register-file array held in the bench and
// checks the stream, status and checksum against an expected-beat queue that
// is built from the requested range whenever a start should be accepted.
// -----------------------------------------------------------------------------
module tb_reg_file_dumper;
  import reg_file_dumper_pkg::*;

  localparam int DW = DEF_DATA_W;
  localparam int AW = DEF_ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_file_dumper_if bus ();

  logic [DW-1:0] regs [NUM_REGS];
  assign bus.rf_read_data = regs[bus.rf_read_reg];

  reg_file_dumper dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus.master)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fires  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: expected beats of the current dump, in order
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } beat_t;

  beat_t         exp_q[$];
  logic          m_busy      = 1'b0;
  logic          m_done      = 1'b0;
  logic          expect_zero = 1'b1;
  logic          prev_stall  = 1'b0;
  logic [AW-1:0] prev_reg    = '0;
  logic [DW-1:0] prev_data   = '0;
  logic [DW-1:0] m_cs        = '0;

  initial begin : compare
    beat_t         b;
    logic          fire;
    logic          done_next;
    logic          busy_next;
    logic [AW-1:0] a;
    forever begin
      @(negedge clk);
      if (expect_zero) begin
        chk("reset_zero", {bus.rf_read_reg, bus.out_valid, bus.out_reg, bus.out_data,
                           bus.busy, bus.done, bus.checksum}, '0);
        expect_zero = 1'b0;
      end
      chk("busy", bus.busy, m_busy);
      chk("done", bus.done, m_done);
      if (!m_busy || m_done) chk("checksum", bus.checksum, m_cs);
      if (!m_busy) chk("idle_valid", bus.out_valid, 1'b0);
      if (prev_stall) begin
        chk("stall_valid", bus.out_valid, 1'b1);
        chk("stall_reg", bus.out_reg, prev_reg);
        chk("stall_data", bus.out_data, prev_data);
      end

      fire      = bus.out_valid && bus.out_ready;
      done_next = 1'b0;
      if (fire) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL extra_beat: actual reg=%0d required no beat", bus.out_reg);
        end else begin
          b = exp_q.pop_front();
          chk("beat_reg", bus.out_reg, b.r);
          chk("beat_data", bus.out_data, b.d);
          n_fires++;
          done_next = (exp_q.size() == 0);
        end
      end

      busy_next = m_busy && !m_done;
      if (bus.start && !m_busy) begin
        a    = bus.first_reg;
        m_cs = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
          b.r = a;
          b.d = regs[a];
          exp_q.push_back(b);
          m_cs = m_cs ^ regs[a];
          if (a == bus.last_reg) break;
          a = a + AW'(1);
        end
        busy_next = 1'b1;
        n_fires   = 0;
      end

      prev_stall = bus.out_valid && !bus.out_ready;
      prev_reg   = bus.out_reg;
      prev_data  = bus.out_data;
      m_done     = done_next;
      m_busy     = busy_next;

      if (rst) begin
        exp_q.delete();
        m_busy      = 1'b0;
        m_done      = 1'b0;
        m_cs        = '0;
        prev_stall  = 1'b0;
        expect_zero = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  // mode 0: always ready; 1: random ready; 2: not ready until cycle 7
  function automatic logic rdy(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return 1'($urandom_range(0, 1));
      default: return (k >= 7);
    endcase
  endfunction

  // k counts cycles after the start cycle (k=1 is the cycle after start).
  task automatic run_dump(input logic [AW-1:0] first, input logic [AW-1:0] last,
                          input int mode, input int inject_k, input int reset_after,
                          output int beats, output int first_valid, output int done_k);
    bit did_rst;
    did_rst     = 1'b0;
    beats       = 0;
    first_valid = -1;
    done_k      = -1;
    tick();
    bus.first_reg = first;
    bus.last_reg  = last;
    bus.start     = 1'b1;
    bus.out_ready = rdy(mode, 0);
    tick();
    bus.start     = 1'b0;
    bus.out_ready = rdy(mode, 1);
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (bus.out_valid && first_valid < 0) first_valid = k;
      if (bus.out_valid && bus.out_ready) beats++;
      if (mode == 2 && k == 6) begin
        chk("stall_hold_valid", bus.out_valid, 1'b1);
        chk("stall_hold_reg", bus.out_reg, first);
        chk("stall_hold_data", bus.out_data, regs[first]);
        chk("stall_no_done", bus.done, 1'b0);
      end
      if (bus.done) begin
        done_k = k;
        break;
      end
      tick();
      if (did_rst) begin
        rst = 1'b0;
        return;
      end
      bus.out_ready = rdy(mode, k + 1);
      bus.start     = (k == inject_k);
      if (bus.start) begin
        bus.first_reg = first + AW'(3);
        bus.last_reg  = first;
      end
      if (reset_after > 0 && beats >= reset_after) begin
        rst     = 1'b1;
        did_rst = 1'b1;
      end
    end
    if (done_k < 0) begin
      n_checks++;
      $display("FAIL dump_timeout: actual no done within 400 cycles required done (first=%0d last=%0d)",
               first, last);
    end
  endtask

  initial begin : stim
    int            beats;
    int            fv;
    int            dk;
    int            exp_n;
    logic [AW-1:0] f;
    logic [AW-1:0] l;
    int            mode;
    int            inj;

    bus.start     = 1'b0;
    bus.first_reg = '0;
    bus.last_reg  = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'(i) * 32'h1111_1111;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Full sweep, consumer always ready
    run_dump(5'd0, 5'd31, 0, -1, 0, beats, fv, dk);
    $display("dump 0..31 ready=1: beats=%0d first_valid=%0d done_cycle=%0d", beats, fv, dk);
    chk("full_first_valid", fv, 2);
    chk("full_done_cycle", dk, 34);
    chk("full_beats", beats, 32);
    chk("full_model_beats", n_fires, 32);

    // Wrapping range 30,31,0,1
    run_dump(5'd30, 5'd1, 0, -1, 0, beats, fv, dk);
    $display("dump 30..1 ready=1: beats=%0d done_cycle=%0d checksum=%08h", beats, dk, bus.checksum);
    chk("wrap_beats", beats, 4);
    chk("wrap_done_cycle", dk, 6);
    chk("wrap_checksum", bus.checksum, 32'hFFFF_FFE0);
    chk("wrap_model_cs", m_cs, 32'hFFFF_FFE0);

    // Single register with a five-cycle stall
    run_dump(5'd7, 5'd7, 2, -1, 0, beats, fv, dk);
    $display("dump 7..7 stalled: beats=%0d done_cycle=%0d checksum=%08h", beats, dk, bus.checksum);
    chk("single_beats", beats, 1);
    chk("single_done_cycle", dk, 8);
    chk("single_checksum", bus.checksum, 32'h7777_7777);
    chk("single_model_cs", m_cs, 32'h7777_7777);

    // Full sweep with random back-pressure
    run_dump(5'd0, 5'd31, 1, -1, 0, beats, fv, dk);
    $display("dump 0..31 ready=random: beats=%0d done_cycle=%0d", beats, dk);
    chk("rand_full_beats", beats, 32);

    // Reset after 10 beats, then a short dump
    run_dump(5'd0, 5'd31, 0, -1, 10, beats, fv, dk);
    $display("dump 0..31 reset after %0d beats", beats);
    chk("reset_no_done", (dk < 0), 1'b1);
    run_dump(5'd5, 5'd6, 0, -1, 0, beats, fv, dk);
    $display("dump 5..6 after reset: beats=%0d done_cycle=%0d", beats, dk);
    chk("after_reset_beats", beats, 2);
    chk("after_reset_done_cycle", dk, 4);

    // start while busy is ignored
    run_dump(5'd10, 5'd20, 0, 5, 0, beats, fv, dk);
    $display("dump 10..20 with start while busy: beats=%0d done_cycle=%0d", beats, dk);
    chk("busy_start_beats", beats, 11);
    chk("busy_start_done_cycle", dk, 13);

    // start in the done cycle is ignored
    run_dump(5'd3, 5'd4, 0, 3, 0, beats, fv, dk);
    $display("dump 3..4 with start on done: beats=%0d done_cycle=%0d", beats, dk);
    chk("done_start_beats", beats, 2);

    // Randomised register contents, ranges and back-pressure
    for (int t = 0; t < 10; t++) begin
      for (int i = 1; i < NUM_REGS; i++) regs[i] = $urandom;
      regs[0] = '0;
      f     = AW'($urandom_range(0, NUM_REGS - 1));
      l     = AW'($urandom_range(0, NUM_REGS - 1));
      mode  = $urandom_range(0, 1);
      inj   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 6)) : -1;
      exp_n = int'(AW'(l - f)) + 1;
      run_dump(f, l, mode, inj, 0, beats, fv, dk);
      $display("dump %0d..%0d mode=%0d: beats=%0d done_cycle=%0d checksum=%08h",
               f, l, mode, beats, dk, bus.checksum);
      chk("rand_beats", beats, exp_n);
    end

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_reg_file_dumper
